// File: rtl/cosim_pkg.sv
// Shared sizing helpers for the co-simulation change monitor.
package cosim_pkg;

  localparam int DROP_W = 16;

  // Index width that stays legal for a single channel.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int event_w(input int nch, input int w, input int ts_w);
    return idx_w(nch) + w + ts_w;
  endfunction

endpackage

// File: rtl/cosim_event_fifo.sv
// Synchronous first-word-fall-through event FIFO with occupancy output.
module cosim_event_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head,
  output logic                   valid,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign valid   = (count != '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && valid;
  assign do_push = push && !full;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/cosim_change_monitor.sv
// Watches NCH values, timestamps changes and queues {chan,value,time} events
// for the co-sim host to drain through a valid/ready port.
module cosim_change_monitor
  import cosim_pkg::*;
#(
  parameter int NCH      = 4,
  parameter int W        = 32,
  parameter int DEPTH    = 8,
  parameter int TS_W     = 32,
  parameter int COALESCE = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NCH*W-1:0]          ch_value,
  input  logic [NCH-1:0]            ch_enable,
  output logic                      ev_valid,
  input  logic                      ev_ready,
  output logic [idx_w(NCH)-1:0]     ev_chan,
  output logic [W-1:0]              ev_value,
  output logic [TS_W-1:0]           ev_time,
  output logic [$clog2(DEPTH):0]    ev_count,
  output logic [DROP_W-1:0]         drop_count
);

  localparam int CHAN_W = idx_w(NCH);
  localparam int EV_W   = event_w(NCH, W, TS_W);

  logic [TS_W-1:0]   ts;
  logic              armed;
  logic [W-1:0]      prev_q [NCH];
  logic [NCH-1:0]    chg;

  logic [NCH-1:0]    pend_p0;
  logic [W-1:0]      pend_val_p0 [NCH];
  logic [TS_W-1:0]   pend_ts_p0 [NCH];

  logic [CHAN_W-1:0] rr_ptr;
  logic [CHAN_W-1:0] cand;
  logic              grant_vld;
  logic [CHAN_W-1:0] grant_idx;
  logic [NCH-1:0]    gnt_oh;
  logic [NCH-1:0]    drop_vec;
  int unsigned       n_drop;

  logic [EV_W-1:0]   push_data;
  logic [EV_W-1:0]   head;
  logic              fifo_valid;
  logic              fifo_full;
  logic [CHAN_W-1:0] head_chan;
  logic [W-1:0]      head_value;
  logic [TS_W-1:0]   head_time;

  function automatic logic [CHAN_W-1:0] next_idx(input logic [CHAN_W-1:0] i);
    return (i == CHAN_W'(NCH-1)) ? '0 : i + 1'b1;
  endfunction

  function automatic logic [DROP_W-1:0] sat_add(input logic [DROP_W-1:0] a,
                                                input int unsigned n);
    logic [DROP_W:0] s;
    s = {1'b0, a} + (DROP_W+1)'(n);
    return s[DROP_W] ? '1 : s[DROP_W-1:0];
  endfunction

  always_comb begin
    chg = '0;
    for (int i = 0; i < NCH; i++)
      chg[i] = armed && ch_enable[i] && (ch_value[i*W +: W] != prev_q[i]);
  end

  // Round-robin grant; a full FIFO holds every pending entry in place.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = rr_ptr;
    for (int k = 0; k < NCH; k++) begin
      if (!fifo_full && !grant_vld && pend_p0[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
      cand = next_idx(cand);
    end
  end

  always_comb begin
    gnt_oh   = '0;
    drop_vec = '0;
    n_drop   = 0;
    for (int i = 0; i < NCH; i++) begin
      gnt_oh[i]   = grant_vld && (grant_idx == CHAN_W'(i));
      drop_vec[i] = chg[i] && pend_p0[i] && !gnt_oh[i];
      n_drop      = n_drop + 32'(drop_vec[i]);
    end
  end

  // Stage p0: detection into the per-channel pending slot
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts         <= '0;
      armed      <= 1'b0;
      pend_p0    <= '0;
      rr_ptr     <= '0;
      drop_count <= '0;
      for (int i = 0; i < NCH; i++) prev_q[i] <= '0;
    end else begin
      ts         <= ts + 1'b1;
      armed      <= 1'b1;
      drop_count <= sat_add(drop_count, n_drop);
      if (grant_vld) rr_ptr <= next_idx(grant_idx);
      for (int i = 0; i < NCH; i++) begin
        prev_q[i] <= ch_value[i*W +: W];
        if (chg[i])         pend_p0[i] <= 1'b1;
        else if (gnt_oh[i]) pend_p0[i] <= 1'b0;
      end
    end
  end

  // A free slot keeps the first-change time; coalescing only refreshes the value.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NCH; i++) begin
      if (chg[i]) begin
        if (!pend_p0[i] || gnt_oh[i]) begin
          pend_val_p0[i] <= ch_value[i*W +: W];
          pend_ts_p0[i]  <= ts;
        end else if (COALESCE != 0) begin
          pend_val_p0[i] <= ch_value[i*W +: W];
        end
      end
    end
  end

  // Stage p1: granted pending entry enters the event FIFO
  assign push_data = {grant_idx, pend_val_p0[grant_idx], pend_ts_p0[grant_idx]};

  cosim_event_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EV_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (grant_vld),
    .push_data (push_data),
    .pop       (ev_ready),
    .head      (head),
    .valid     (fifo_valid),
    .full      (fifo_full),
    .count     (ev_count)
  );

  assign {head_chan, head_value, head_time} = head;
  assign ev_valid = fifo_valid;
  assign ev_chan  = fifo_valid ? head_chan  : '0;
  assign ev_value = fifo_valid ? head_value : '0;
  assign ev_time  = fifo_valid ? head_time  : '0;

endmodule
